// File: rtl/qspi_rd_ctrl.sv
// rtl/qspi_rd_ctrl.sv - quad-SPI flash single-word read controller (0xEB quad I/O fast read)
//
// Turns one 32-bit read request into a full quad I/O fast-read transaction:
// 8 command clocks (single line), 6 address clocks, 2 mode clocks, 4 dummy
// clocks and 8 data clocks, then returns the assembled word.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_addr_i               byte address, [23:0] sent on the bus
//   rsp_valid_o              one-cycle response pulse
//   rsp_rdata_o, rsp_err_o   response word (held) and error flag
//   busy_o                   controller not idle
//   qspi_io_i/o/t            quad data lines in/out, per-line release (1 = released)
//   qspi_ck_o, qspi_cs_o     flash clock (mode 0) and active-low chip select
//
// Optional feature macro: QSPI_RD_CTRL_ADDR_CHK_EN (reject unaligned or
// out-of-range addresses without touching the bus).

module qspi_rd_ctrl #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned CS_IDLE   = 2,
    parameter logic [7:0]  MODE_BYTE = 8'hF0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    input  logic [3:0]  qspi_io_i,
    output logic [3:0]  qspi_io_o,
    output logic [3:0]  qspi_io_t,
    output logic        qspi_ck_o,
    output logic        qspi_cs_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_GAP
    } state_e;

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(CS_IDLE - 1);
    localparam logic [7:0]       CMD_QIO_RD  = 8'hEB;
    localparam logic [4:0]       LAST_PERIOD = 5'd27;

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [GAP_W-1:0]   gap_q;
    logic [4:0]         per_q;
    logic [4:0]         per_d;
    logic [23:0]        addr_q;
    logic [31:0]        sh_q;
    logic               ck_q;
    logic               cs_q;
    logic [3:0]         io_o_q;
    logic [3:0]         io_t_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;
    logic               addr_bad;

`ifdef QSPI_RD_CTRL_ADDR_CHK_EN
    assign addr_bad = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:24] != 8'h00);
`else
    logic unused_addr_hi;
    assign addr_bad       = 1'b0;
    assign unused_addr_hi = ^req_addr_i[31:24];
`endif

    assign per_d = per_q + 5'd1;

    // Which bus phase a given ck period (0..27) belongs to.
    function automatic state_e phase_of(input logic [4:0] p);
        if (p < 5'd8)  return S_CMD;
        if (p < 5'd14) return S_ADDR;
        if (p < 5'd16) return S_MODE;
        if (p < 5'd20) return S_DUMMY;
        return S_DATA;
    endfunction

    // Pin values for ck period p: returns {io_t, io_o}.
    function automatic logic [7:0] lane_drive(input logic [4:0] p, input logic [23:0] a);
        logic [3:0] o;
        logic [3:0] t;
        o = 4'h0;
        t = 4'hF;
        if (p < 5'd8) begin
            // Command goes out single-line on io[0]; other lines stay released.
            o = {3'b000, CMD_QIO_RD[3'd7 - p[2:0]]};
            t = 4'b1110;
        end else if (p < 5'd16) begin
            t = 4'h0;
            case (p)
                5'd8:    o = a[23:20];
                5'd9:    o = a[19:16];
                5'd10:   o = a[15:12];
                5'd11:   o = a[11:8];
                5'd12:   o = a[7:4];
                5'd13:   o = a[3:0];
                5'd14:   o = MODE_BYTE[7:4];
                default: o = MODE_BYTE[3:0];
            endcase
        end
        return {t, o};
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            gap_q       <= '0;
            per_q       <= '0;
            addr_q      <= '0;
            sh_q        <= '0;
            ck_q        <= 1'b0;
            cs_q        <= 1'b1;
            io_o_q      <= 4'h0;
            io_t_q      <= 4'hF;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (addr_bad) begin
                            // Rejected request: answer immediately, bus untouched.
                            state_q     <= S_GAP;
                            gap_q       <= GAP_LAST;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q            <= S_CMD;
                            cs_q               <= 1'b0;
                            ck_q               <= 1'b0;
                            div_q              <= '0;
                            per_q              <= '0;
                            addr_q             <= req_addr_i[23:0];
                            {io_t_q, io_o_q}   <= lane_drive(5'd0, req_addr_i[23:0]);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        ck_q  <= ~ck_q;
                        if (!ck_q) begin
                            // Rising ck edge: flash samples our lines, we sample theirs.
                            if (state_q == S_DATA) begin
                                sh_q <= {sh_q[27:0], qspi_io_i};
                            end
                        end else if (per_q == LAST_PERIOD) begin
                            // Final falling edge ends the transaction.
                            state_q     <= S_GAP;
                            gap_q       <= GAP_LAST;
                            cs_q        <= 1'b1;
                            io_o_q      <= 4'h0;
                            io_t_q      <= 4'hF;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            // Bytes arrive in address order, high nibble first.
                            rsp_rdata_q <= {sh_q[7:0], sh_q[15:8], sh_q[23:16], sh_q[31:24]};
                        end else begin
                            // Falling ck edge: move to the next period's pin values.
                            per_q            <= per_d;
                            state_q          <= phase_of(per_d);
                            {io_t_q, io_o_q} <= lane_drive(per_d, addr_q);
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign qspi_io_o   = io_o_q;
    assign qspi_io_t   = io_t_q;
    assign qspi_ck_o   = ck_q;
    assign qspi_cs_o   = cs_q;

endmodule

// File: doc/qspi_rd_ctrl.md
# qspi_rd_ctrl

Synthesizable quad-SPI flash read controller: turns single 32-bit word read requests into a quad I/O fast-read (command 0xEB) transaction on the QSPI pins and returns the assembled word. It is the initiator that faces the flash model used in simulation and the external boot/program flash on silicon, and it sits between the core's instruction/data fetch path and the pad ring.

## Interface
Parameters:
- CLK_DIV, 2, QSPI clock half-period in clk_i cycles (>= 1)
- CS_IDLE, 2, minimum clk_i cycles with qspi_cs_o high between transactions (>= 1)
- MODE_BYTE, 8'hF0, mode byte sent after the address; bits [7:4] must be 4'hF

Ports:
- clk_i  in  1  single clock
- rst_ni  in  1  reset, synchronous, active-low
- req_valid_i  in  1  read request valid
- req_ready_o  out  1  high in IDLE only
- req_addr_i  in  32  byte address; [23:0] sent on bus
- rsp_valid_o  out  1  one-cycle pulse, no backpressure
- rsp_rdata_o  out  32  read word, held until next response
- rsp_err_o  out  1  error flag, qualified by rsp_valid_o
- busy_o  out  1  high whenever state != IDLE
- qspi_io_i  in  4  data from flash
- qspi_io_o  out  4  data to flash
- qspi_io_t  out  4  per-line tristate enable, 1 = released
- qspi_ck_o  out  1  QSPI clock, idles low (mode 0)
- qspi_cs_o  out  1  chip select, active-low

## Operation
- States: IDLE, CMD (8 ck), ADDR (6 ck), MODE (2 ck), DUMMY (4 ck), DATA (8 ck), GAP.
- Accept on req_valid_i & req_ready_o in IDLE; address latched; go to CMD.
- CMD: 0xEB MSB first on io_o[0]; qspi_io_t = 4'b1110.
- ADDR: addr[23:0], nibble MSB first, nibble bit j on io line j; qspi_io_t = 4'h0.
- MODE: MODE_BYTE high nibble then low nibble; qspi_io_t = 4'h0.
- DUMMY and DATA: qspi_io_t = 4'hF, qspi_io_o = 4'h0.
- DATA nibbles n0..n7 in arrival order; rsp_rdata_o = {n6,n7,n4,n5,n2,n3,n0,n1} (each byte high-nibble first, bytes little-endian).
- After 28th ck cycle: cs high, rsp_valid_o pulse, enter GAP for CS_IDLE cycles, then IDLE.
- Reset values: qspi_cs_o=1, qspi_ck_o=0, qspi_io_o=0, qspi_io_t=4'hF, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0, req_ready_o=1 (IDLE).
- Reset mid-transaction: all outputs to reset values on the next clk edge, cs rises, no response issued, shift state discarded.

## Timing
- Accept at cycle T; T+1: cs low, ck low, cmd bit 7 driven.
- ck rises at T+1+CLK_DIV, toggles every CLK_DIV cycles; 28 full ck periods.
- Outputs change only on ck falling edges (and at T+1); flash samples on rising edges.
- qspi_io_i registered in the clk cycle where ck_o goes 0->1 during DATA; flash drives on falling edges.
- rsp_valid_o, cs high at T+1+56*CLK_DIV (CLK_DIV=2: T+113).
- req_ready_o high again at T+1+56*CLK_DIV+CS_IDLE; back-to-back requests accepted that cycle.
- Requests while not ready are ignored (not queued).

## Configuration
- QSPI_RD_CTRL_ADDR_CHK_EN defined: a request with req_addr_i[1:0] != 0 or req_addr_i[31:24] != 0 is not issued on the bus. It goes straight to GAP. rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0 at T+1, and cs stays high.
- Undefined: rsp_err_o tied 0; req_addr_i[23:0] always sent unchanged, upper bits ignored.

## Test plan
- Reset held 3 cycles mid-traffic -> every output at its listed reset value; req_ready_o=1 after release.
- Flash model word index 0x40 = 0x12345678, read 0x000100 (CLK_DIV=2) -> io_o[0] shows 0xEB, address nibbles 0,0,0,1,0,0, mode 0xF0, rsp_rdata_o=0x12345678 at T+113, rsp_err_o=0.
- req_valid_i held high for two reads (0x0, 0x4) -> second accepted exactly CS_IDLE cycles after the first rsp_valid_o; cs high >= CS_IDLE cycles; both words correct.
- rst_ni low for 1 cycle during ADDR -> cs high next cycle, no rsp_valid_o; a following read of 0x0 returns correct data.
- CLK_DIV=1, CS_IDLE=1 -> rsp_valid_o at T+57, ready at T+58.
- req_addr_i=0x00000102: with QSPI_RD_CTRL_ADDR_CHK_EN -> rsp_err_o=1 at T+1, cs never low. Without the macro -> bus address 0x000102, rsp_err_o=0.
